// File: rtl/mem_io_responder.sv
// Responder for the CPU byte bus: main RAM plus the memory-mapped I/O window
// (UART TX/RX FIFOs, free-running cycle counter with snapshot, program-stop).
module mem_io_responder #(
    parameter int ADDR_WIDTH  = 17,
    parameter int TX_DEPTH    = 8,
    parameter int RX_DEPTH    = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        halt,
    output logic        tx_overflow
);

    localparam int TX_PW = $clog2(TX_DEPTH) + 1;
    localparam int RX_PW = $clog2(RX_DEPTH) + 1;
    localparam logic [17:0] IO_UART = 18'h30000;
    localparam logic [17:0] IO_STOP = 18'h30004;

    logic [7:0] ram_mem [2**ADDR_WIDTH];
    logic [7:0] tx_mem  [TX_DEPTH];
    logic [7:0] rx_mem  [RX_DEPTH];
    logic [7:0] ram_rd_q;

    logic [TX_PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [RX_PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [31:0]      counter_q, counter_d, snapshot_q, snapshot_d;
    logic             halt_q, halt_d, tx_ovf_q, tx_ovf_d;
    logic [7:0]       io_rd_q, io_rd_d;
    logic             sel_ram_q, sel_ram_d;

    logic [17:0]           io_addr;
    logic                  is_io;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [TX_PW-1:0]      tx_count;
    logic                  tx_empty, tx_full, rx_empty, rx_full;
    logic                  tx_push, tx_accept, tx_pop, rx_push, rx_pop;
    logic [7:0]            tx_push_data;
    logic                  unused_bits;

    assign io_addr  = cpu_a[17:0];
    assign is_io    = (io_addr[17:16] == 2'b11);
    assign ram_addr = cpu_a[ADDR_WIDTH-1:0];
    assign ram_we   = cpu_wr && !is_io;

    // Pointers carry one extra wrap bit: equal -> empty, differ only in MSB -> full.
    assign tx_count = tx_wr_q - tx_rd_q;
    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q == {~tx_rd_q[TX_PW-1], tx_rd_q[TX_PW-2:0]});
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q == {~rx_rd_q[RX_PW-1], rx_rd_q[RX_PW-2:0]});

    assign tx_valid       = !tx_empty;
    assign tx_data        = tx_empty ? '0 : tx_mem[tx_rd_q[TX_PW-2:0]];
    assign rx_ready       = !rx_full;
    assign io_buffer_full = (TX_DEPTH - int'(tx_count)) <= FULL_MARGIN;
    assign halt           = halt_q;
    assign tx_overflow    = tx_ovf_q;
    assign cpu_din        = sel_ram_q ? ram_rd_q : io_rd_q;
    assign unused_bits    = ^{cpu_a[31:18], snapshot_q[7:0]};

    always_comb begin
        tx_push      = 1'b0;
        tx_push_data = '0;
        rx_pop       = 1'b0;
        io_rd_d      = '0;
        sel_ram_d    = !cpu_wr && !is_io;
        halt_d       = halt_q;
        snapshot_d   = snapshot_q;

        if (is_io && cpu_wr) begin
            if (io_addr == IO_UART && cpu_dout != '0) begin
                tx_push      = 1'b1;
                tx_push_data = cpu_dout;
            end else if (io_addr == IO_STOP) begin
                halt_d  = 1'b1;
                tx_push = 1'b1;
            end
        end else if (is_io) begin
            if (io_addr == IO_UART) begin
                if (!rx_empty) begin
                    rx_pop  = 1'b1;
                    io_rd_d = rx_mem[rx_rd_q[RX_PW-2:0]];
                end
            end else if (io_addr[17:2] == IO_STOP[17:2]) begin
                // Byte 0 returns the live count and latches it so bytes 1..3 stay coherent.
                case (io_addr[1:0])
                    2'd0: begin
                        io_rd_d    = counter_q[7:0];
                        snapshot_d = counter_q;
                    end
                    2'd1:    io_rd_d = snapshot_q[15:8];
                    2'd2:    io_rd_d = snapshot_q[23:16];
                    default: io_rd_d = snapshot_q[31:24];
                endcase
            end
        end

        tx_accept = tx_push && !tx_full;
        tx_pop    = !tx_empty && tx_ready;
        rx_push   = rx_valid && !rx_full;
        tx_ovf_d  = tx_ovf_q || (tx_push && tx_full);
        tx_wr_d   = tx_wr_q + (tx_accept ? TX_PW'(1) : '0);
        tx_rd_d   = tx_rd_q + (tx_pop    ? TX_PW'(1) : '0);
        rx_wr_d   = rx_wr_q + (rx_push   ? RX_PW'(1) : '0);
        rx_rd_d   = rx_rd_q + (rx_pop    ? RX_PW'(1) : '0);
        counter_d = halt_q ? counter_q : counter_q + 32'd1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            counter_q  <= '0;
            snapshot_q <= '0;
            halt_q     <= 1'b0;
            tx_ovf_q   <= 1'b0;
            io_rd_q    <= '0;
            sel_ram_q  <= 1'b0;
        end else begin
            tx_wr_q    <= tx_wr_d;
            tx_rd_q    <= tx_rd_d;
            rx_wr_q    <= rx_wr_d;
            rx_rd_q    <= rx_rd_d;
            counter_q  <= counter_d;
            snapshot_q <= snapshot_d;
            halt_q     <= halt_d;
            tx_ovf_q   <= tx_ovf_d;
            io_rd_q    <= io_rd_d;
            sel_ram_q  <= sel_ram_d;
        end
    end

    // Storage arrays are never reset; the output mux hides stale RAM data after reset.
    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram_mem[ram_addr] <= cpu_dout;
        end
        ram_rd_q <= ram_mem[ram_addr];
    end

    always_ff @(posedge clk_in) begin
        if (tx_accept) begin
            tx_mem[tx_wr_q[TX_PW-2:0]] <= tx_push_data;
        end
        if (rx_push) begin
            rx_mem[rx_wr_q[RX_PW-2:0]] <= rx_data;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized bench for mem_io_responder against a queue/array reference model.
module tb_mem_io_responder;

    localparam int AW  = 17;
    localparam int TXD = 8;
    localparam int RXD = 8;
    localparam int FM  = 2;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        halt;
    logic        tx_overflow;

    always #5 clk_in = ~clk_in;

    mem_io_responder #(
        .ADDR_WIDTH (AW),
        .TX_DEPTH   (TXD),
        .RX_DEPTH   (RXD),
        .FULL_MARGIN(FM)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .cpu_a         (cpu_a),
        .cpu_dout      (cpu_dout),
        .cpu_wr        (cpu_wr),
        .cpu_din       (cpu_din),
        .io_buffer_full(io_buffer_full),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .halt          (halt),
        .tx_overflow   (tx_overflow)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Reference model state
    logic [7:0]  ram_m [int];
    logic [7:0]  txq [$];
    logic [7:0]  rxq [$];
    logic [31:0] m_cnt;
    logic [31:0] m_snap;
    bit          m_halt;
    bit          m_ovf;
    logic [7:0]  m_din;
    bit          m_din_known;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        txq.delete();
        rxq.delete();
        m_cnt       = '0;
        m_snap      = '0;
        m_halt      = 1'b0;
        m_ovf       = 1'b0;
        m_din       = '0;
        m_din_known = 1'b1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_cpu_din"}, cpu_din, 8'h00);
        check({pfx, "_tx_valid"}, tx_valid, 1'b0);
        check({pfx, "_tx_data"}, tx_data, 8'h00);
        check({pfx, "_io_full"}, io_buffer_full, 1'b0);
        check({pfx, "_halt"}, halt, 1'b0);
        check({pfx, "_tx_ovf"}, tx_overflow, 1'b0);
        check({pfx, "_rx_ready"}, rx_ready, 1'b1);
    endtask

    // One bus cycle: drive at negedge, advance the model across the posedge, compare at next negedge.
    task automatic cycle(input logic [31:0] a, input logic wr, input logic [7:0] d,
                         input logic txr, input logic rxv, input logic [7:0] rxd);
        logic [17:0] a18;
        bit          io, full_pre, do_pop, do_rx_push, halt_pre, push_tx;
        logic [7:0]  push_byte;
        int          key;
        cpu_a = a; cpu_wr = wr; cpu_dout = d; tx_ready = txr; rx_valid = rxv; rx_data = rxd;
        a18        = a[17:0];
        io         = (a18[17:16] == 2'b11);
        full_pre   = (txq.size() == TXD);
        do_pop     = (txq.size() != 0) && txr;
        do_rx_push = rxv && (rxq.size() < RXD);
        halt_pre   = m_halt;
        push_tx    = 1'b0;
        push_byte  = 8'h00;
        m_din       = 8'h00;
        m_din_known = 1'b1;
        key = int'(a[AW-1:0]);
        if (wr) begin
            if (io && a18 == 18'h30000 && d != 8'h00) begin
                push_tx = 1'b1; push_byte = d;
            end else if (io && a18 == 18'h30004) begin
                push_tx = 1'b1; push_byte = 8'h00; m_halt = 1'b1;
            end else if (!io) begin
                ram_m[key] = d;
            end
        end else if (io) begin
            if (a18 == 18'h30000) begin
                if (rxq.size() != 0) m_din = rxq.pop_front();
            end else if (a18 >= 18'h30004 && a18 <= 18'h30007) begin
                if (a18[1:0] == 2'd0) begin
                    m_din  = m_cnt[7:0];
                    m_snap = m_cnt;
                end else begin
                    m_din = m_snap[int'(a18[1:0]) * 8 +: 8];
                end
            end
        end else if (ram_m.exists(key)) begin
            m_din = ram_m[key];
        end else begin
            m_din_known = 1'b0;
        end
        if (do_pop) void'(txq.pop_front());
        if (push_tx) begin
            if (full_pre) m_ovf = 1'b1;
            else          txq.push_back(push_byte);
        end
        if (do_rx_push) rxq.push_back(rxd);
        if (!halt_pre) m_cnt = m_cnt + 32'd1;

        @(posedge clk_in);
        @(negedge clk_in);
        if (m_din_known) check("cpu_din", cpu_din, m_din);
        check("tx_valid", tx_valid, txq.size() != 0);
        check("tx_data", tx_data, (txq.size() != 0) ? txq[0] : 8'h00);
        check("io_buffer_full", io_buffer_full, (TXD - txq.size()) <= FM);
        check("rx_ready", rx_ready, rxq.size() < RXD);
        check("halt", halt, m_halt);
        check("tx_overflow", tx_overflow, m_ovf);
    endtask

    task automatic idle(input logic txr);
        cycle(32'h0003_0008, 1'b0, 8'h00, txr, 1'b0, 8'h00);
    endtask

    task automatic drain_tx();
        for (int i = 0; i < 3 * TXD && txq.size() != 0; i++) idle(1'b1);
        check("tx_drained", tx_valid, 1'b0);
    endtask

    task automatic drain_rx();
        for (int i = 0; i < 3 * RXD && rxq.size() != 0; i++)
            cycle(32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic random_cycles(input int n);
        int          r;
        logic [16:0] ra;
        logic [13:0] up;
        logic        b17, txr, rxv;
        logic [7:0]  d;
        logic [17:0] oth_rd [5];
        logic [17:0] oth_wr [6];
        oth_rd = '{18'h30001, 18'h30003, 18'h30008, 18'h3FFFF, 18'h3000C};
        oth_wr = '{18'h30001, 18'h30002, 18'h30003, 18'h30005, 18'h30008, 18'h3FFFC};
        for (int i = 0; i < n; i++) begin
            r   = int'($urandom_range(0, 99));
            up  = 14'($urandom);
            ra  = 17'($urandom_range(0, 31)) | ($urandom_range(0, 1) != 0 ? 17'h10000 : 17'h0);
            b17 = ra[16] ? 1'b0 : 1'($urandom);
            txr = ($urandom_range(0, 2) == 0);
            rxv = ($urandom_range(0, 1) == 0);
            d   = 8'($urandom);
            if (r < 25)      cycle({up, b17, ra}, 1'b1, d, txr, rxv, 8'($urandom));
            else if (r < 50) cycle({up, b17, ra}, 1'b0, d, txr, rxv, 8'($urandom));
            else if (r < 62) cycle({up, 18'h30000}, 1'b1, ($urandom_range(0, 4) == 0) ? 8'h00 : d,
                                   txr, rxv, 8'($urandom));
            else if (r < 75) cycle({up, 18'h30000}, 1'b0, d, txr, rxv, 8'($urandom));
            else if (r < 88) cycle({up, 16'hC001, 2'($urandom)}, 1'b0, d, txr, rxv, 8'($urandom));
            else if (r < 94) cycle({up, oth_rd[$urandom_range(0, 4)]}, 1'b0, d, txr, rxv, 8'($urandom));
            else             cycle({up, oth_wr[$urandom_range(0, 5)]}, 1'b1, d, txr, rxv, 8'($urandom));
        end
    endtask

    logic [31:0] frozen;

    initial begin
        rst_n_in = 1'b0;
        cpu_a = '0; cpu_wr = 1'b0; cpu_dout = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(negedge clk_in);
        check_reset_outputs("rst");
        rst_n_in = 1'b1;
        model_reset();

        // RAM read-after-write
        cycle(32'h0000_0123, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
        cycle(32'h0000_0123, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check("ram_raw", cpu_din, 8'hA5);

        // Snapshot-consistent counter read at 0x1FF
        for (int i = 0; i < 600 && m_cnt != 32'h1FF; i++) idle(1'b0);
        cycle(32'h0003_0004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check("cnt_b0", cpu_din, 8'hFF);
        cycle(32'h0003_0005, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check("cnt_b1", cpu_din, 8'h01);
        cycle(32'h0003_0006, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check("cnt_b2", cpu_din, 8'h00);
        cycle(32'h0003_0007, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check("cnt_b3", cpu_din, 8'h00);

        // TX: zero bytes are not queued
        drain_tx();
        cycle(32'h0003_0000, 1'b1, 8'h41, 1'b1, 1'b0, 8'h00);
        check("tx_seq0", tx_data, 8'h41);
        cycle(32'h0003_0000, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00);
        check("tx_seq_gap", tx_valid, 1'b0);
        cycle(32'h0003_0000, 1'b1, 8'h42, 1'b1, 1'b0, 8'h00);
        check("tx_seq1", tx_data, 8'h42);
        drain_tx();

        // TX nearly-full threshold and overflow
        for (int i = 1; i <= 9; i++) begin
            cycle(32'h0003_0000, 1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
            if (i == 5) check("io_full_5", io_buffer_full, 1'b0);
            if (i == 6) check("io_full_6", io_buffer_full, 1'b1);
            if (i == 8) check("ovf_8", tx_overflow, 1'b0);
            if (i == 9) check("ovf_9", tx_overflow, 1'b1);
        end
        drain_tx();

        // RX FIFO
        drain_rx();
        cycle(32'h0003_0008, 1'b0, 8'h00, 1'b0, 1'b1, 8'h31);
        cycle(32'h0003_0008, 1'b0, 8'h00, 1'b0, 1'b1, 8'h32);
        cycle(32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check("rx_0", cpu_din, 8'h31);
        cycle(32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check("rx_1", cpu_din, 8'h32);
        cycle(32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check("rx_empty", cpu_din, 8'h00);

        random_cycles(1500);

        // Program stop
        drain_tx();
        cycle(32'h0003_0004, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00);
        check("halt_set", halt, 1'b1);
        check("halt_tx_valid", tx_valid, 1'b1);
        check("halt_tx_zero", tx_data, 8'h00);
        frozen = m_cnt;
        repeat (4) idle(1'b1);
        cycle(32'h0003_0004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check("cnt_frozen", cpu_din, frozen[7:0]);

        random_cycles(300);

        // Reset while a RAM read is in flight
        cycle(32'h0000_0123, 1'b1, 8'hA5, 1'b0, 1'b1, 8'h55);
        cpu_a = 32'h0000_0123; cpu_wr = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
        @(posedge clk_in);
        #1;
        check("pre_rst_din", cpu_din, 8'hA5);
        rst_n_in = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        model_reset();
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        cycle(32'h0003_0004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        cycle(32'h0003_0005, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        cycle(32'h0000_0123, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check("ram_kept", cpu_din, 8'hA5);
        random_cycles(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
